// File: rtl/btc_dec_iter_sched.sv
// ----------------------------------------------------------------------------------------------
// btc_dec_iter_sched
//
// Half-iteration scheduler for the BTC decoder engine. Once the input buffer holds a frame it
// runs max(iNiter,1) iterations, each a row pass followed by a column pass over the
// inrow x ceil(incol/pDEC_NUM) word array, then releases the input buffer. One word is issued
// per enabled clock; passes never stall. Between passes the scheduler waits for the engine's
// idone.
//
// Optional feature: define BTC_DEC_ITER_SCHED_EARLY_STOP_EN to force the next iteration to be
// the last one when a whole non-last iteration finished without idecfail.
//
// Ports
//   iclk, ireset      clock, asynchronous active-low reset
//   iclkena           clock enable; all state frozen when low
//   inrow, incol      product code geometry, sampled at frame start
//   iNiter            iteration count (0 treated as 1), sampled at frame start
//   irbuf_full        input buffer holds a frame
//   iwbuf_empty       output buffer free (gates the start of the last iteration)
//   idone, idecfail   engine finished a pass / pass had uncorrected codewords
//   obuf_rempty       1-cycle pulse: input buffer released
//   obuf_addr         word read address
//   orow_mode         1 = row pass, 0 = column pass
//   odec_val          per-lane valid of the word at obuf_addr
//   odec_sof/eof/eop  first / last word of a component codeword, last word of the pass
//   ohalf_idx         half-iteration index 2*iter + (column pass)
//   ostart_iter       pulse with the first word of the frame
//   olast_iter        high for the whole final iteration
// ----------------------------------------------------------------------------------------------
module btc_dec_iter_sched #(
    parameter int unsigned pADDR_W  = 8,
    parameter int unsigned pDEC_NUM = 8,
    parameter int unsigned pN_W     = 6
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic [pN_W-1:0]     inrow,
    input  logic [pN_W-1:0]     incol,
    input  logic [3:0]          iNiter,
    input  logic                irbuf_full,
    input  logic                iwbuf_empty,
    input  logic                idone,
    input  logic                idecfail,
    output logic                obuf_rempty,
    output logic [pADDR_W-1:0]  obuf_addr,
    output logic                orow_mode,
    output logic [pDEC_NUM-1:0] odec_val,
    output logic                odec_sof,
    output logic                odec_eof,
    output logic                odec_eop,
    output logic [4:0]          ohalf_idx,
    output logic                ostart_iter,
    output logic                olast_iter
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRow,
        StWrow,
        StCol,
        StWcol,
        StRel
    } state_e;

    state_e state_q, state_d;

    // Frame parameters latched at frame start
    logic [pN_W-1:0] nrow_q, nrow_d;
    logic [pN_W-1:0] ncol_q, ncol_d;
    logic [pN_W-1:0] w_q, w_d;        // words per row
    logic [3:0]      niter_q, niter_d;

    // Iteration / pass bookkeeping
    logic [3:0]         iter_q, iter_d;
    logic               force_last_q, force_last_d;
    logic               fail_acc_q, fail_acc_d;
    logic [pN_W-1:0]    r_q, r_d;
    logic [pN_W-1:0]    cw_q, cw_d;
    logic [pADDR_W-1:0] addr_q, addr_d;

    // Registered outputs
    logic                rempty_q, rempty_d;
    logic [pADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic                row_mode_q, row_mode_d;
    logic [pDEC_NUM-1:0] val_q, val_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic                eop_q, eop_d;
    logic [4:0]          half_q, half_d;
    logic                start_q, start_d;
    logic                last_q, last_d;

    logic                is_last;
    logic                cw_last;
    logic                r_last;
    logic [pDEC_NUM-1:0] lane_mask;

    assign is_last = (iter_q == niter_q - 4'd1) || force_last_q;
    assign cw_last = (cw_q == w_q - 1'b1);
    assign r_last  = (r_q == nrow_q - 1'b1);

    // Lane i of column-word cw carries column cw*pDEC_NUM+i; lanes past incol are padding.
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < pDEC_NUM; i++) begin
            if ((32'(cw_q) * pDEC_NUM + i) < 32'(ncol_q)) begin
                lane_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        nrow_d       = nrow_q;
        ncol_d       = ncol_q;
        w_d          = w_q;
        niter_d      = niter_q;
        iter_d       = iter_q;
        force_last_d = force_last_q;
        fail_acc_d   = fail_acc_q;
        r_d          = r_q;
        cw_d         = cw_q;
        addr_d       = addr_q;

        rempty_d   = 1'b0;
        buf_addr_d = '0;
        val_d      = '0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        eop_d      = 1'b0;
        start_d    = 1'b0;
        row_mode_d = row_mode_q;
        half_d     = half_q;
        last_d     = last_q;

        unique case (state_q)
            StIdle: begin
                if (irbuf_full) begin
                    nrow_d       = inrow;
                    ncol_d       = incol;
                    w_d          = pN_W'((32'(incol) + pDEC_NUM - 1) / pDEC_NUM);
                    niter_d      = (iNiter == 4'd0) ? 4'd1 : iNiter;
                    iter_d       = 4'd0;
                    force_last_d = 1'b0;
                    fail_acc_d   = 1'b0;
                    r_d          = '0;
                    cw_d         = '0;
                    addr_d       = '0;
                    state_d      = StCheck;
                end
            end

            StCheck: begin
                // The last iteration writes the output buffer, so it waits for it to be free.
                if (!(is_last && !iwbuf_empty)) begin
                    last_d  = is_last;
                    state_d = StRow;
                end
            end

            StRow: begin
                buf_addr_d = addr_q;
                val_d      = lane_mask;
                sof_d      = (cw_q == '0);
                eof_d      = cw_last;
                eop_d      = cw_last && r_last;
                start_d    = (iter_q == 4'd0) && (r_q == '0) && (cw_q == '0);
                row_mode_d = 1'b1;
                half_d     = {iter_q, 1'b0};
                if (cw_last && r_last) begin
                    r_d     = '0;
                    cw_d    = '0;
                    addr_d  = '0;
                    state_d = StWrow;
                end else if (cw_last) begin
                    cw_d   = '0;
                    r_d    = r_q + 1'b1;
                    addr_d = addr_q + pADDR_W'(1);
                end else begin
                    cw_d   = cw_q + 1'b1;
                    addr_d = addr_q + pADDR_W'(1);
                end
            end

            StWrow: begin
                if (idone) begin
                    fail_acc_d = fail_acc_q | idecfail;
                    state_d    = StCol;
                end
            end

            StCol: begin
                buf_addr_d = addr_q;
                val_d      = lane_mask;
                sof_d      = (r_q == '0);
                eof_d      = r_last;
                eop_d      = cw_last && r_last;
                row_mode_d = 1'b0;
                half_d     = {iter_q, 1'b1};
                if (cw_last && r_last) begin
                    r_d     = '0;
                    cw_d    = '0;
                    addr_d  = '0;
                    state_d = StWcol;
                end else if (r_last) begin
                    // Next column-word starts again at row 0.
                    r_d    = '0;
                    cw_d   = cw_q + 1'b1;
                    addr_d = pADDR_W'(cw_q) + pADDR_W'(1);
                end else begin
                    r_d    = r_q + 1'b1;
                    addr_d = addr_q + pADDR_W'(w_q);
                end
            end

            StWcol: begin
                if (idone) begin
                    fail_acc_d = fail_acc_q | idecfail;
                    if (is_last) begin
                        state_d = StRel;
                    end else begin
`ifdef BTC_DEC_ITER_SCHED_EARLY_STOP_EN
                        // A clean iteration: one more pass pair to write the output, then stop.
                        if (!(fail_acc_q | idecfail)) begin
                            force_last_d = 1'b1;
                        end
`endif
                        iter_d     = iter_q + 4'd1;
                        fail_acc_d = 1'b0;
                        state_d    = StCheck;
                    end
                end
            end

            StRel: begin
                rempty_d = 1'b1;
                last_d   = 1'b0;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifndef BTC_DEC_ITER_SCHED_EARLY_STOP_EN
    // Without early stop the failure flag is tracked but never steers the schedule.
    logic unused_fail_acc;
    assign unused_fail_acc = fail_acc_q;
`endif

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q      <= StIdle;
            nrow_q       <= '0;
            ncol_q       <= '0;
            w_q          <= '0;
            niter_q      <= '0;
            iter_q       <= '0;
            force_last_q <= 1'b0;
            fail_acc_q   <= 1'b0;
            r_q          <= '0;
            cw_q         <= '0;
            addr_q       <= '0;
            rempty_q     <= 1'b0;
            buf_addr_q   <= '0;
            row_mode_q   <= 1'b0;
            val_q        <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            eop_q        <= 1'b0;
            half_q       <= '0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
        end else if (iclkena) begin
            state_q      <= state_d;
            nrow_q       <= nrow_d;
            ncol_q       <= ncol_d;
            w_q          <= w_d;
            niter_q      <= niter_d;
            iter_q       <= iter_d;
            force_last_q <= force_last_d;
            fail_acc_q   <= fail_acc_d;
            r_q          <= r_d;
            cw_q         <= cw_d;
            addr_q       <= addr_d;
            rempty_q     <= rempty_d;
            buf_addr_q   <= buf_addr_d;
            row_mode_q   <= row_mode_d;
            val_q        <= val_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            eop_q        <= eop_d;
            half_q       <= half_d;
            start_q      <= start_d;
            last_q       <= last_d;
        end
    end

    assign obuf_rempty = rempty_q;
    assign obuf_addr   = buf_addr_q;
    assign orow_mode   = row_mode_q;
    assign odec_val    = val_q;
    assign odec_sof    = sof_q;
    assign odec_eof    = eof_q;
    assign odec_eop    = eop_q;
    assign ohalf_idx   = half_q;
    assign ostart_iter = start_q;
    assign olast_iter  = last_q;

endmodule

// File: tb/tb_btc_dec_iter_sched.sv
module tb_btc_dec_iter_sched;

`ifdef BTC_DEC_ITER_SCHED_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       iclk = 1'b0;
    logic       ireset;
    logic       iclkena;
    logic [5:0] inrow;
    logic [5:0] incol;
    logic [3:0] iNiter;
    logic       irbuf_full;
    logic       iwbuf_empty;
    logic       idone;
    logic       idecfail;
    logic       obuf_rempty;
    logic [7:0] obuf_addr;
    logic       orow_mode;
    logic [7:0] odec_val;
    logic       odec_sof;
    logic       odec_eof;
    logic       odec_eop;
    logic [4:0] ohalf_idx;
    logic       ostart_iter;
    logic       olast_iter;

    btc_dec_iter_sched #(
        .pADDR_W (8),
        .pDEC_NUM(8),
        .pN_W    (6)
    ) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .inrow      (inrow),
        .incol      (incol),
        .iNiter     (iNiter),
        .irbuf_full (irbuf_full),
        .iwbuf_empty(iwbuf_empty),
        .idone      (idone),
        .idecfail   (idecfail),
        .obuf_rempty(obuf_rempty),
        .obuf_addr  (obuf_addr),
        .orow_mode  (orow_mode),
        .odec_val   (odec_val),
        .odec_sof   (odec_sof),
        .odec_eof   (odec_eof),
        .odec_eop   (odec_eop),
        .ohalf_idx  (ohalf_idx),
        .ostart_iter(ostart_iter),
        .olast_iter (olast_iter)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int nr;
        int nc;
        int ni;
        int fail;       // percent chance idecfail=1 on a real idone
        int en_pct;     // percent chance iclkena=1
        bit hold;       // hold iwbuf_empty=0 when the last iteration is due
        bit abort;      // reset in the middle of the first column pass
        int exp_words;  // -1: not checked
        int exp_done;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int addr_log[$];
    int val_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] snap();
        return {obuf_rempty, obuf_addr, odec_val, odec_sof, odec_eof, odec_eop, orow_mode,
                ohalf_idx, ostart_iter, olast_iter};
    endfunction

    task automatic run_frame(input vec_t v, output int words, output int dones);
        int w, l, ni, m_iter, idx, wdelay, cyc, rempty_cnt, hold_cnt;
        int r, cw;
        bit m_last, m_col, fail_it, forced, waiting, expect_rel, fin, started, hold_on;
        bit en, done_real, drv_fail, disp_word, disp_eop, aborted;
        logic [27:0] cur, prev;
        logic [26:0] expw;
        logic [7:0]  mask;

        w = (v.nc + 7) / 8;
        l = v.nr * w;
        ni = (v.ni == 0) ? 1 : v.ni;
        m_iter = 0; idx = 0; wdelay = 0; cyc = 0; rempty_cnt = 0; hold_cnt = 0;
        m_col = 0; fail_it = 0; forced = 0; waiting = 0; expect_rel = 0; fin = 0;
        started = 0; disp_word = 0; disp_eop = 0; aborted = 0; drv_fail = 0;
        m_last = (ni == 1);
        hold_on = v.hold && m_last;
        words = 0; dones = 0;
        addr_log.delete();
        val_log.delete();
        prev = snap();

        inrow = 6'(v.nr);
        incol = 6'(v.nc);
        iNiter = 4'(v.ni);
        irbuf_full = 1'b1;

        while (!fin && !aborted && cyc < 20000) begin
            cyc++;
            en = hold_on ? 1'b1 : ($urandom_range(99) < v.en_pct);
            iclkena = en;
            iwbuf_empty = hold_on ? 1'b0 : ($urandom_range(3) != 0);
            done_real = 0;
            if (waiting && wdelay == 0) begin
                drv_fail = ($urandom_range(99) < v.fail);
                idone = 1'b1;
                idecfail = drv_fail;
                done_real = 1;
            end else begin
                if (waiting) wdelay--;
                // idone while a pass is still issuing words must be ignored
                idone = disp_word && !disp_eop && ($urandom_range(3) == 0);
                idecfail = 1'($urandom_range(1));
            end

            @(posedge iclk);
            #1;
            cur = snap();
            if (!en) begin
                check("held_while_disabled", 64'(cur), 64'(prev));
            end else begin
                if (odec_val != 0) begin
                    if (waiting || expect_rel || idx >= l) begin
                        check("extra_word", 1, 0);
                    end else begin
                        if (!m_col) begin
                            r = idx / w;
                            cw = idx % w;
                        end else begin
                            cw = idx / v.nr;
                            r = idx % v.nr;
                        end
                        mask = '0;
                        for (int i = 0; i < 8; i++) if (cw * 8 + i < v.nc) mask[i] = 1'b1;
                        expw = {8'(r * w + cw), mask,
                                m_col ? (r == 0) : (cw == 0),
                                m_col ? (r == v.nr - 1) : (cw == w - 1),
                                (idx == l - 1), !m_col, 5'(2 * m_iter + int'(m_col)),
                                (m_iter == 0 && !m_col && idx == 0), m_last};
                        check($sformatf("word it%0d %s idx%0d", m_iter, m_col ? "col" : "row", idx),
                              64'(cur[26:0]), 64'(expw));
                        addr_log.push_back(int'(obuf_addr));
                        val_log.push_back(int'(odec_val));
                        words++;
                        if (idx == l - 1) begin
                            waiting = 1;
                            wdelay = $urandom_range(3);
                        end
                        idx++;
                    end
                    if (!started) begin
                        // Later changes on these inputs must not disturb the running frame.
                        started = 1;
                        irbuf_full = 1'b0;
                        inrow = 6'($urandom);
                        incol = 6'($urandom);
                        iNiter = 4'($urandom);
                    end
                end else begin
                    check("quiet_flags", 64'({odec_sof, odec_eof, odec_eop, ostart_iter}), 64'(0));
                end
                if (obuf_rempty) begin
                    rempty_cnt++;
                    check("rempty_when_due", 64'(expect_rel), 64'(1));
                    fin = 1;
                end
            end
            prev = cur;
            disp_word = (odec_val != 0);
            disp_eop = odec_eop;

            if (hold_on) begin
                check("last_iter_waits_wbuf", 64'({odec_val != 0, olast_iter}), 64'(0));
                hold_cnt++;
                if (hold_cnt == 12) hold_on = 0;
            end

            if (en && done_real) begin
                dones++;
                waiting = 0;
                fail_it = fail_it | drv_fail;
                if (!m_col) begin
                    m_col = 1;
                    idx = 0;
                end else if (m_last) begin
                    expect_rel = 1;
                end else begin
                    m_iter++;
                    forced = EARLY && !fail_it;
                    fail_it = 0;
                    m_last = (m_iter == ni - 1) || forced;
                    m_col = 0;
                    idx = 0;
                    if (v.hold && m_last) begin
                        hold_on = 1;
                        hold_cnt = 0;
                    end
                end
            end

            if (v.abort && m_col && idx >= 2) begin
                ireset = 1'b0;
                #1;
                check("abort_outputs_now", 64'(snap()), 64'(0));
                @(posedge iclk);
                #1;
                check("abort_outputs_edge", 64'(snap()), 64'(0));
                irbuf_full = 1'b0;
                idone = 1'b0;
                iclkena = 1'b1;
                ireset = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(posedge iclk);
                    #1;
                    check("abort_no_rempty", 64'({obuf_rempty, odec_val != 0}), 64'(0));
                end
                aborted = 1;
            end
        end

        if (!aborted) begin
            check("rempty_count", 64'(rempty_cnt), 64'(1));
            idone = 1'b0;
            iclkena = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(posedge iclk);
                #1;
                check("idle_after_release", 64'({obuf_rempty, odec_val != 0, olast_iter}), 64'(0));
            end
        end
    endtask

    vec_t tbl[10];
    vec_t rv;
    int   words, dones;
    int   exp2_addr[12];

    initial begin
        // W = ceil(nc/8); words = 2 * nr * W * iterations; dones = 2 * iterations
        tbl[0] = '{4, 8, 1, 0, 100, 1'b0, 1'b0, 8, 2};
        tbl[1] = '{3, 12, 1, 0, 100, 1'b0, 1'b0, 12, 2};
        tbl[2] = '{5, 20, 3, 100, 100, 1'b1, 1'b0, 90, 6};
        tbl[3] = '{2, 5, 8, 0, 100, 1'b0, 1'b0, EARLY ? 8 : 32, EARLY ? 4 : 16};
        tbl[4] = '{6, 17, 2, 0, 50, 1'b0, 1'b0, 72, 4};
        tbl[5] = '{1, 9, 0, 100, 100, 1'b0, 1'b0, 4, 2};
        tbl[6] = '{4, 16, 2, 0, 100, 1'b0, 1'b1, -1, -1};
        tbl[7] = '{3, 3, 1, 0, 100, 1'b0, 1'b0, 6, 2};
        tbl[8] = '{7, 63, 2, 100, 70, 1'b0, 1'b0, 224, 4};
        tbl[9] = '{63, 1, 1, 0, 100, 1'b1, 1'b0, 126, 2};
        exp2_addr = '{0, 1, 2, 3, 4, 5, 0, 2, 4, 1, 3, 5};

        ireset = 1'b0;
        iclkena = 1'b1;
        inrow = '0;
        incol = '0;
        iNiter = '0;
        irbuf_full = 1'b0;
        iwbuf_empty = 1'b1;
        idone = 1'b0;
        idecfail = 1'b0;
        #1;
        check("reset_outputs", 64'(snap()), 64'(0));
        @(negedge iclk);
        @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);

        for (int t = 0; t < 10; t++) begin
            run_frame(tbl[t], words, dones);
            if (tbl[t].exp_words >= 0) begin
                check($sformatf("frame%0d_words", t), 64'(words), 64'(tbl[t].exp_words));
                check($sformatf("frame%0d_dones", t), 64'(dones), 64'(tbl[t].exp_done));
            end
            if (t == 1) begin
                for (int k = 0; k < 12; k++) begin
                    check($sformatf("nr3nc12_addr%0d", k),
                          64'(k < addr_log.size() ? addr_log[k] : -1), 64'(exp2_addr[k]));
                end
                check("nr3nc12_val_cw0", 64'(val_log.size() > 0 ? val_log[0] : -1), 64'(8'hFF));
                check("nr3nc12_val_cw1", 64'(val_log.size() > 1 ? val_log[1] : -1), 64'(8'h0F));
                check("nr3nc12_colval", 64'(val_log.size() > 9 ? val_log[9] : -1), 64'(8'h0F));
            end
        end

        for (int t = 0; t < 6; t++) begin
            rv.nr = $urandom_range(1, 20);
            rv.nc = $urandom_range(1, 40);
            rv.ni = $urandom_range(0, 4);
            rv.fail = 30;
            rv.en_pct = $urandom_range(40, 100);
            rv.hold = 1'b0;
            rv.abort = 1'b0;
            rv.exp_words = -1;
            rv.exp_done = -1;
            run_frame(rv, words, dones);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
